// File: rtl/sar_ctrl.sv
// Successive-approximation controller for an NBIT SAR ADC.
// Tracks the input while CKS is high, then runs a binary search on the
// DAC code from comparator decisions after CKS falls, and publishes the
// result on DOUT with a one-cycle VALID strobe.
module sar_ctrl #(
  parameter int NBIT   = 8,
  parameter int SETTLE = 1
) (
  input  logic            CK,
  input  logic            RSTN,
  input  logic            EN,
  input  logic            CKS,
  input  logic            CMP,
  output logic            SAMPLE,
  output logic [NBIT-1:0] DAC,
  output logic [NBIT-1:0] DOUT,
  output logic            VALID,
  output logic            BUSY,
  output logic            MISS
);

  localparam int IW = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE);
  localparam logic [IW-1:0]   IDX_TOP  = IW'(NBIT - 1);
  localparam logic [NBIT-1:0] DAC_MID  = {1'b1, {(NBIT-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAMP = 2'd1,
    CONV = 2'd2
  } state_t;

  state_t          state, state_n;
  logic            cks_q;
  logic            rise, fall;
  logic [IW-1:0]   idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            sample_n, valid_n, busy_n, miss_n;
  logic [NBIT-1:0] dac_n, dout_n;

  assign rise = CKS & ~cks_q;
  assign fall = ~CKS & cks_q;

  // Next-state and next-output logic for the sample/convert sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    sample_n = SAMPLE;
    dac_n    = DAC;
    dout_n   = DOUT;
    busy_n   = BUSY;
    valid_n  = 1'b0;
    miss_n   = 1'b0;

    if (!EN) begin
      // Abort: drop back to idle without publishing anything; DOUT keeps its old value.
      state_n  = IDLE;
      sample_n = 1'b0;
      dac_n    = '0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_n  = SAMP;
            sample_n = 1'b1;
            busy_n   = 1'b1;
          end
        end

        SAMP: begin
          if (fall) begin
            state_n  = CONV;
            sample_n = 1'b0;
            dac_n    = DAC_MID;
            idx_n    = IDX_TOP;
            cnt_n    = '0;
          end
        end

        CONV: begin
          // A new sample period cannot start mid-conversion; flag it and carry on.
          if (rise) miss_n = 1'b1;
          if (cnt == CNT_LAST) begin
            cnt_n      = '0;
            dac_n[idx] = CMP;
            if (idx != '0) begin
              dac_n[idx - 1'b1] = 1'b1;
              idx_n             = idx - 1'b1;
            end else begin
              dout_n  = {DAC[NBIT-1:1], CMP};
              valid_n = 1'b1;
              dac_n   = '0;
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end

        default: begin
          state_n  = IDLE;
          sample_n = 1'b0;
          dac_n    = '0;
          busy_n   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset clears everything, including DOUT.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= IDLE;
      cks_q  <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      SAMPLE <= 1'b0;
      DAC    <= '0;
      DOUT   <= '0;
      VALID  <= 1'b0;
      BUSY   <= 1'b0;
      MISS   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state  <= state_n;
      cks_q  <= CKS;
      idx    <= idx_n;
      cnt    <= cnt_n;
      SAMPLE <= sample_n;
      DAC    <= dac_n;
      DOUT   <= dout_n;
      VALID  <= valid_n;
      BUSY   <= busy_n;
      MISS   <= miss_n;
    end
  end

endmodule
